uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- Self-timed UART transmitter. Serialises one 8-bit byte per frame onto the uart_tx line: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- It is the transmit end of the same 9600 bps link served by the receive-side baud-tick generator. It runs on the same 25 MHz clock.
- Upstream logic hands bytes in over a valid/ready handshake. An internal bit-period counter replaces the external bps_start/clk_bps pair.

Parameters:
- CLKS_PER_BIT, 2604, clk cycles per bit (25_000_000/9600, truncated). Legal range 2..65535.
- PARITY_ODD, 0, used only when UART_TX_PARITY_EN is defined. 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  system clock, 25 MHz
- rst_n  input  1  reset; asynchronous, active-low
- tx_data  input  8  byte to send; sampled on the handshake cycle
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  block can accept a byte this cycle
- uart_tx  output  1  serial line, idle high
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset values: state IDLE, uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter=0, shift register=0. Reset is asynchronous and may occur mid-frame. On reset the line returns to 1 immediately and the partially sent frame is abandoned; no tx_done is issued.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- tx_ready = (state==IDLE). It is decoded from the state register only and has no combinational path from tx_valid.
- A handshake occurs when tx_valid and tx_ready are both 1 at a rising clk edge. On that edge:
  - tx_data is latched into the shift register;
  - state goes to START and the period counter is cleared.
- Latency: if the handshake is at edge N, uart_tx is 0 from edge N to edge N+CLKS_PER_BIT. tx_busy is 1 over the same interval.
- Period counter: 16 bits, counts 0..CLKS_PER_BIT-1. A bit ends when counter==CLKS_PER_BIT-1; the counter then wraps to 0 and the next bit starts on that edge. Every bit therefore lasts exactly CLKS_PER_BIT cycles.
- START: line 0 for one bit period, then go to DATA with bit index 0.
- DATA: line = shift register bit 0. At each bit end, shift right and increment the 3-bit index. After index 7 ends, go to PARITY if the macro is defined, otherwise to STOP.
- STOP: line 1 for one bit period. At its end:
  - tx_done=1 for exactly that one cycle;
  - state returns to IDLE;
  - tx_busy=0 and tx_ready=1 from the next edge.
- Back-to-back transfers: with tx_valid held high, the next handshake happens on the first IDLE cycle. Frame period without parity is 10*CLKS_PER_BIT+1 cycles, including one idle-high cycle between frames.
- Ignored inputs: tx_data and tx_valid are ignored while busy. A byte presented while busy is not lost; it is accepted once tx_ready rises, provided tx_valid is still held.
- uart_tx is driven from a flop and must be glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - a PARITY state of one bit period is inserted between DATA and STOP;
  - the parity bit is ^data (even parity) or ~^data (odd parity), per PARITY_ODD;
  - the parity bit is computed from the latched byte at handshake time;
  - frame period becomes 11*CLKS_PER_BIT+1 cycles.
- Undefined: the PARITY state, its logic and the PARITY_ODD effect are absent, and the frame is 10 bits.

Test Plan:
- Reset check: assert rst_n=0 -> uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0 for the whole reset. Release reset with tx_valid=0 -> line stays 1 for 1000 cycles.
- Single byte, CLKS_PER_BIT=16: send 0xA5 -> line samples taken at mid-bit are 0,1,0,1,0,0,1,0,1,1. The start bit falls at the handshake edge. tx_done pulses once, 160 cycles after the handshake. The line is re-sampled by a reference UART receiver model and returns 0xA5.
- Back-to-back, CLKS_PER_BIT=16: tx_valid held high with 0x00, 0xFF, 0x55 -> three frames with handshakes exactly 161 cycles apart. Received bytes are 0x00, 0xFF, 0x55.
- Busy hold-off: change tx_data and pulse tx_valid mid-frame -> no effect on the current frame. tx_ready stays 0 until the cycle after tx_done.
- Reset mid-frame: assert rst_n during data bit 3 of 0x0F -> uart_tx=1 immediately, with no tx_done. The next frame, 0x3C, is correct.
- Parity, with the macro defined, CLKS_PER_BIT=16:
  - PARITY_ODD=0: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame period 177 cycles.
  - PARITY_ODD=1: send 0x07 -> parity bit 0.

Source files
------------

// File: rtl/uart_byte_tx.sv
// uart_byte_tx - self-timed UART transmitter.
//
// Sends one byte per frame on uart_tx: start bit (0), 8 data bits LSB first,
// optional parity bit, stop bit (1). Bytes arrive over a valid/ready
// handshake. An internal 16-bit period counter times every bit to exactly
// CLKS_PER_BIT clock cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data bits and the stop bit (even parity, or odd when PARITY_ODD=1).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled on the handshake edge
//   tx_valid  upstream has a byte
//   tx_ready  block accepts a byte this cycle (decoded from state only)
//   uart_tx   serial line, idle high, driven from a flop
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse during the final cycle of the stop bit

module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        line_q, line_n;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_n;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      line_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shift  <= shift_n;
      line_q <= line_n;
`ifdef UART_TX_PARITY_EN
      par_q  <= par_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    bit_end = (cnt == CNT_LAST);
    cnt_n   = bit_end ? '0 : cnt + 16'd1;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid) begin
          state_n = START;
          shift_n = tx_data;
`ifdef UART_TX_PARITY_EN
          par_n   = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs. The line level is computed from the next state so the
  // registered uart_tx changes on the same edge as the state it belongs to.
  always_comb begin
    line_n = 1'b1;
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_n = par_n;
`endif
      default: line_n = 1'b1;
    endcase

    tx_ready = (state == IDLE);
    tx_busy  = (state != IDLE);
    tx_done  = (state == STOP) && bit_end;
    uart_tx  = line_q;
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx - self-checking bench for uart_byte_tx with CLKS_PER_BIT=16.
// Line activity is recorded into history arrays and compared against a
// frame-level reference model and a reference UART receiver.
// With UART_TX_PARITY_EN defined a second instance with PARITY_ODD=1 runs on
// the same stimulus.

module tb_uart_byte_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int P   = NB * CPB + 1;
  localparam int LEN = 1100;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, tx_busy, tx_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic h_line [0:LEN-1];
  logic h_done [0:LEN-1];
  logic h_ready[0:LEN-1];
  logic h_odd  [0:LEN-1];
  logic h_octl [0:LEN-1];
  ev_t  evq[$];

  always #5 clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic ready_odd, line_odd, busy_odd, done_odd;
  uart_byte_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_odd), .uart_tx(line_odd), .tx_busy(busy_odd), .tx_done(done_odd)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample k is taken 1ns after edge H+k, where H is the edge preceding the call.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      h_line[k]  = uart_tx;
      h_done[k]  = tx_done;
      h_ready[k] = tx_ready;
`ifdef UART_TX_PARITY_EN
      h_odd[k]   = line_odd;
      h_octl[k]  = ({ready_odd, busy_odd, done_odd} === {tx_ready, tx_busy, tx_done});
`else
      h_odd[k]   = uart_tx;
      h_octl[k]  = 1'b1;
`endif
      foreach (evq[i]) if (evq[i].k == k) begin
        tx_data  = evq[i].d;
        tx_valid = evq[i].v;
      end
      tick();
    end
    evq.delete();
  endtask

  task automatic add_ev(input int k, input logic [7:0] d, input logic v);
    ev_t e;
    e.k = k; e.d = d; e.v = v;
    evq.push_back(e);
  endtask

  // Expected frame, bit 0 = start bit; unused upper bits are idle-high.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
    logic [10:0] f;
    f = {2'b11, d, 1'b0};
    if (NB == 11) f[9] = (^d) ^ odd;
    return f;
  endfunction

  // Reference receiver: first high-to-low transition at or after 'from'.
  function automatic int find_fall(input int from);
    for (int k = from; k < LEN; k++)
      if (h_line[k] == 1'b0 && (k == 0 || h_line[k-1] == 1'b1)) return k;
    return -1;
  endfunction

  function automatic logic [7:0] rx_decode(input int s);
    logic [7:0] b;
    b = '0;
    if (s < 0) return 8'hxx;
    for (int i = 0; i < 8; i++) b[i] = h_line[s + CPB/2 + CPB*(i+1)];
    return b;
  endfunction

  // Checks one frame whose handshake edge corresponds to sample h.
  task automatic check_frame(input string tag, input int h, input logic [7:0] b);
    logic [10:0] obs, obs_o;
    int s, nd, octl_bad;
    obs = '1; obs_o = '1;
    for (int i = 0; i < NB; i++) begin
      obs[i]   = h_line[h + i*CPB + CPB/2];
      obs_o[i] = h_odd[h + i*CPB + CPB/2];
    end
    check({tag, "_bits"}, 32'(obs), 32'(frame_bits(b, 1'b0)));
`ifdef UART_TX_PARITY_EN
    check({tag, "_bits_odd"}, 32'(obs_o), 32'(frame_bits(b, 1'b1)));
`endif
    s = find_fall((h >= CPB/2) ? h - CPB/2 : 0);
    check({tag, "_start"}, 32'(s), 32'(h));
    check({tag, "_rx"}, 32'(rx_decode(s)), 32'(b));
    check({tag, "_stop"}, 32'(h_line[s + CPB/2 + CPB*(NB-1)]), 32'd1);
    nd = 0; octl_bad = 0;
    for (int k = h; k <= h + NB*CPB; k++) begin
      if (h_done[k]) nd++;
      if (!h_octl[k]) octl_bad++;
    end
    check({tag, "_done_cnt"}, 32'(nd), 32'd1);
    check({tag, "_done_at"}, 32'(h_done[h + NB*CPB - 1]), 32'd1);
    check({tag, "_ready_lo"}, 32'(h_ready[h + NB*CPB - 1]), 32'd0);
    check({tag, "_ready_hi"}, 32'(h_ready[h + NB*CPB]), 32'd1);
    check({tag, "_odd_ctl"}, 32'(octl_bad), 32'd0);
  endtask

  task automatic send_one(input string tag, input logic [7:0] b);
    check({tag, "_ready_pre"}, 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    capture(NB*CPB + 2);
    check_frame(tag, 0, b);
  endtask

  initial begin
    int ones, rdy;
    logic [7:0] r;

    // Reset held: idle outputs throughout.
    tick();
    for (int i = 0; i < 5; i++) begin
      check("reset_hold", 32'({uart_tx, tx_ready, tx_busy, tx_done}), 32'b1100);
      tick();
    end
    rst_n = 1'b1;
    capture(1000);
    ones = 0; rdy = 0;
    for (int k = 0; k < 1000; k++) begin
      if (h_line[k]) ones++;
      if (h_ready[k]) rdy++;
    end
    check("idle_line", 32'(ones), 32'd1000);
    check("idle_ready", 32'(rdy), 32'd1000);

    // Single byte, plus random bytes.
    send_one("a5", 8'hA5);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      send_one($sformatf("rnd%0d", i), r);
    end

    // Back-to-back with tx_valid held high.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    add_ev(10, 8'hFF, 1'b1);
    add_ev(P + 10, 8'h55, 1'b1);
    add_ev(2*P + 10, 8'h55, 1'b0);
    capture(3*P + 10);
    check_frame("b2b0", 0, 8'h00);
    check_frame("b2b1", P, 8'hFF);
    check_frame("b2b2", 2*P, 8'h55);

    // Busy hold-off: a pulse mid-frame is ignored, a held byte waits.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    add_ev(0, 8'hC3, 1'b0);
    add_ev(40, 8'h5A, 1'b1);
    add_ev(41, 8'h5A, 1'b0);
    add_ev(80, 8'h99, 1'b1);
    add_ev(P + 5, 8'h99, 1'b0);
    capture(2*P + 5);
    check_frame("hold0", 0, 8'hC3);
    rdy = 0;
    for (int k = 0; k < P - 1; k++) if (h_ready[k]) rdy++;
    check("hold_ready_low", 32'(rdy), 32'd0);
    check_frame("hold1", P, 8'h99);

    // Reset during data bit 3 of 0x0F.
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 4*CPB + CPB/2; i++) tick();
    check("mid_busy", 32'(tx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_now", 32'({uart_tx, tx_ready, tx_busy, tx_done}), 32'b1100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_hold", 32'({uart_tx, tx_ready, tx_busy, tx_done}), 32'b1100);
    end
    rst_n = 1'b1;
    tick();
    send_one("after_rst", 8'h3C);

`ifdef UART_TX_PARITY_EN
    send_one("par07", 8'h07);
    check("par07_even", 32'(h_line[9*CPB + CPB/2]), 32'd1);
    check("par07_odd", 32'(h_odd[9*CPB + CPB/2]), 32'd0);
    send_one("par03", 8'h03);
    check("par03_even", 32'(h_line[9*CPB + CPB/2]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
